// File: rtl/jk_cmd_seq_if.sv
// Command handshake between a command source and the JK command sequencer.
interface jk_cmd_seq_if #(
  parameter int WIDTH = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_mask;

  modport master (
    output cmd_valid, cmd_op, cmd_mask,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask,
    output cmd_ready
  );
endinterface

// File: rtl/jk_cmd_seq.sv
// Queues bit-masked JK commands, issues one per clock as registered J/K pulses,
// tracks the expected bank state and flags divergence of the fed-back Q.
module jk_cmd_seq #(
  parameter int WIDTH       = 4,
  parameter int DEPTH       = 4,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  jk_cmd_seq_if.slave            cmd,
  output logic [WIDTH-1:0]       j,
  output logic [WIDTH-1:0]       k,
  input  logic [WIDTH-1:0]       q_fb,
  output logic [WIDTH-1:0]       shadow_q,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   err,
  input  logic                   err_clr
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_RST  = 2'b01,
    OP_SET  = 2'b10,
    OP_TGL  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_e;

  logic [WIDTH+1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d, shad_q, shad_d;
  logic             issued_q, issued_d;
  logic             cmp_pend_q, cmp_pend_d;
  logic             err_q, err_d;
  state_e           state_q, state_d;

  logic             push, pop, mismatch, halt_now;
  op_e              head_op;
  logic [WIDTH-1:0] head_mask;

  assign cmd.cmd_ready = (count_q < FULL);

  always_comb begin
    push      = cmd.cmd_valid && cmd.cmd_ready;
    mismatch  = cmp_pend_q && (q_fb != shad_q);
    // The edge that detects a mismatch must not pop, otherwise a command would
    // slip out on the way into HALT.
    halt_now  = HALT_ON_ERR && mismatch && !err_clr;
    pop       = (state_q != S_HALT) && (count_q != '0) && !halt_now;
    head_op   = op_e'(mem_q[rd_ptr_q][WIDTH+1:WIDTH]);
    head_mask = mem_q[rd_ptr_q][WIDTH-1:0];

    j_d = '0;
    k_d = '0;
    if (pop) begin
      unique case (head_op)
        OP_RST:  k_d = head_mask;
        OP_SET:  j_d = head_mask;
        OP_TGL: begin
          j_d = head_mask;
          k_d = head_mask;
        end
        default: ;
      endcase
    end

    shad_d = shad_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      unique case ({j_q[i], k_q[i]})
        2'b01:   shad_d[i] = 1'b0;
        2'b10:   shad_d[i] = 1'b1;
        2'b11:   shad_d[i] = ~shad_q[i];
        default: shad_d[i] = shad_q[i];
      endcase
    end
    if (err_clr) shad_d = q_fb;

    issued_d   = pop;
    cmp_pend_d = issued_q && !err_clr;
    err_d      = err_clr ? 1'b0 : (err_q || mismatch);

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    state_d = state_q;
    unique case (state_q)
      S_HALT: begin
        if (err_clr) state_d = (count_d != '0) ? S_RUN : S_IDLE;
      end
      default: begin
        if (halt_now)
          state_d = S_HALT;
        else if ((count_d != '0) || issued_d || cmp_pend_d)
          state_d = S_RUN;
        else
          state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      j_q        <= '0;
      k_q        <= '0;
      shad_q     <= '0;
      issued_q   <= 1'b0;
      cmp_pend_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      j_q        <= j_d;
      k_q        <= k_d;
      shad_q     <= shad_d;
      issued_q   <= issued_d;
      cmp_pend_q <= cmp_pend_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd.cmd_op, cmd.cmd_mask};
  end

  assign j          = j_q;
  assign k          = k_q;
  assign shadow_q   = shad_q;
  assign fifo_count = count_q;
  assign err        = err_q;
  assign busy       = (count_q != '0) || issued_q || cmp_pend_q;
endmodule
